multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS core; sits directly upstream of the datapath.
- Consumes Op/Funct from the datapath instruction register and drives every datapath select and write-enable, one state per cycle.
- Adds configurable wait states to cover synchronous block-RAM read latency on fetch and load.

Parameters:
- MEM_RD_LAT, 1, memory read latency in cycles (1..3). Wait-state count before IR or Data is valid.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- Op  in  6  instr[31:26]
- Funct  in  6  instr[5:0]
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load, qualified by Zero in the datapath
- PCSrc  out  1  0 = ALUResult, 1 = ALUOut
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- ALUSrcA  out  1  0 = PC, 1 = A
- RegWrite  out  1  register-file write enable
- lorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = Data
- illegal_op  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Reset: synchronous; while rst_n=0 at a rising edge, state <= FETCH and wait counter <= 0.
- Outputs are Moore (registered state, combinational decode), so during reset they show FETCH values with all write enables 0.
- Every output not listed for a state is 0; ALUControl defaults to 010.
- States and actions:
  - FETCH: lorD=0; holds while wait_cnt < MEM_RD_LAT, no writes; wait_cnt increments each cycle.
  - FETCH final cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCSrc=0; next DECODE; wait_cnt clears.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut).
  - DECODE next state: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXECUTE; beq (000100) -> BRANCH; addi (001000) -> ADDIEX; otherwise illegal_op=1 and next FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add; next MEMRD for lw, MEMWR for sw.
  - MEMRD: lorD=1; holds MEM_RD_LAT cycles using wait_cnt, then MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
  - MEMWR: lorD=1, MemWrite=1 for exactly one cycle; next FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - EXECUTE with unknown funct: illegal_op=1, next FETCH, no RegWrite. Known funct: next ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=1; next FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add; next ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
- CPI with MEM_RD_LAT=1: lw 6, sw 5, R-type 5, addi 5, beq 4.
- Op/Funct are sampled only in DECODE/MEMADR/EXECUTE; the IR is stable there because IRWrite=0.
- Reset mid-instruction: the next edge returns to FETCH. An in-flight MemWrite/RegWrite occurring in the same cycle as the reset edge is suppressed.
- Unreachable state encodings recover to FETCH.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each IRWrite pulse.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg: state enum, opcode constants (RTYPE, LW, SW, BEQ, ADDI), funct constants, ALUControl codes, ALUSrcB codes.
- One sub-module, alu_decoder: combinational (alu_op[1:0], Funct) -> ALUControl plus funct_valid. Instantiated once.

Test Plan:
- Reset held 3 cycles, then released with MEM_RD_LAT=1 -> state FETCH; first cycle all enables 0 and lorD=0; second cycle IRWrite=PCWrite=1 with ALUSrcB=01.
- Op=000000, Funct=100010 -> EXECUTE drives ALUControl=110 and ALUSrcB=00; ALUWB drives RegDst=1 and RegWrite=1; IRWrite-to-IRWrite spacing is 5 cycles.
- Op=100011 with MEM_RD_LAT=3 -> lorD=1 for 3 MEMRD cycles, then MemtoReg=1 and RegWrite=1 for 1 cycle; total 10 cycles.
- Op=101011 -> MemWrite high exactly 1 cycle with lorD=1; RegWrite never asserted during the instruction.
- Op=111111, then separately Op=000000 with Funct=000111 -> illegal_op pulses 1 cycle, no RegWrite/MemWrite, next state FETCH.
- rst_n dropped during MEMWR -> MemWrite=0 at that edge; following cycle is FETCH. With CTRL_PERF_CNT_EN, both counters read 0 after reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding, opcode/funct
// constants, ALU control codes and ALUSrcB select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALUSrcB selects
  localparam logic [1:0] SrcbB      = 2'b00;
  localparam logic [1:0] SrcbFour   = 2'b01;
  localparam logic [1:0] SrcbImm    = 2'b10;
  localparam logic [1:0] SrcbImmSh2 = 2'b11;

  // Coarse ALU operation requested by the FSM; the decoder refines it
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpAddi);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's coarse alu_op plus the R-type funct field to a 3-bit
// ALUControl code. funct_valid drops only for an unrecognised funct under AluOpFunct.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  // Decode ALU operation; unknown funct falls back to add and flags invalid
  always_comb begin
    alu_control = AluAdd;
    funct_valid = 1'b1;
    unique case (alu_op)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct)
          FnAdd:   alu_control = AluAdd;
          FnSub:   alu_control = AluSub;
          FnAnd:   alu_control = AluAnd;
          FnOr:    alu_control = AluOr;
          FnSlt:   alu_control = AluSlt;
          default: funct_valid = 1'b0;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core. Moore outputs decoded from the state
// register, with MEM_RD_LAT wait states on fetch and load. Optional macro
// CTRL_PERF_CNT_EN adds free-running cycle and retired-fetch counters.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       lorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
`ifdef CTRL_PERF_CNT_EN
  output logic       illegal_op,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`else
  output logic       illegal_op
`endif
);

  localparam logic [1:0] Lat   = 2'(MEM_RD_LAT);
  localparam logic [1:0] LatM1 = 2'(MEM_RD_LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic [1:0] alu_op;
  logic       funct_valid;
  logic       fetch_done;

  // Raw enables before reset gating
  logic pc_write_raw, branch_raw, reg_write_raw, mem_write_raw, ir_write_raw;
  logic illegal_raw;

  assign fetch_done = !(wait_q < Lat);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl),
    .funct_valid (funct_valid)
  );

  // State and wait-counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; wait counter only runs in FETCH and MEMRD
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      StFetch: begin
        if (fetch_done) state_d = StDecode;
        else            wait_d  = wait_q + 2'd1;
      end
      StDecode: begin
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (Op == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (wait_q == LatM1) state_d = StMemWb;
        else                 wait_d  = wait_q + 2'd1;
      end
      StExecute: state_d = funct_valid ? StAluWb : StFetch;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StMemWr, StAluWb, StBranch, StAddiWb: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // Moore output decode; unlisted outputs stay 0 and ALU defaults to add
  always_comb begin
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    PCSrc         = 1'b0;
    alu_op        = AluOpAdd;
    ALUSrcB       = SrcbB;
    ALUSrcA       = 1'b0;
    reg_write_raw = 1'b0;
    lorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (fetch_done) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          ALUSrcB      = SrcbFour;
        end
      end
      StDecode:  ALUSrcB = SrcbImmSh2;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcbImm;
      end
      StMemRd:   lorD = 1'b1;
      StMemWb: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      StMemWr: begin
        lorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecute: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpFunct;
      end
      StAluWb: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        alu_op     = AluOpSub;
        branch_raw = 1'b1;
        PCSrc      = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcbImm;
      end
      StAddiWb:  reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  // Kept outside the decode block so funct_valid never feeds back into alu_op's block
  assign illegal_raw = ((state_q == StDecode) && !op_is_legal(Op)) ||
                       ((state_q == StExecute) && !funct_valid);

  // Gate state-changing strobes with rst_n so a write in flight at a reset edge is dropped
  assign PCWrite    = pc_write_raw  & rst_n;
  assign Branch     = branch_raw    & rst_n;
  assign RegWrite   = reg_write_raw & rst_n;
  assign MemWrite   = mem_write_raw & rst_n;
  assign IRWrite    = ir_write_raw  & rst_n;
  assign illegal_op = illegal_raw   & rst_n;

`ifdef CTRL_PERF_CNT_EN
  // Performance counters: cycles out of reset and instruction fetches; both wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (IRWrite) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Two instances (MEM_RD_LAT=1 and 3) share
// Op/Funct; one is held in reset while the other is exercised. Expected per-cycle output
// vectors come from an instruction-level model built from the control rules.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [5:0] op, funct;

  logic       pcw [2], br [2], pcsrc [2], srca [2], rw [2], lord [2], mw [2];
  logic       irw [2], rd [2], m2r [2], ill [2];
  logic [2:0] aluc [2];
  logic [1:0] srcb [2];
  logic [15:0] obs [2];
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] ccnt [2], icnt [2];
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q [$];

  // Vector: {PCWrite,Branch,PCSrc,ALUControl,ALUSrcB,ALUSrcA,RegWrite,lorD,MemWrite,
  //          IRWrite,RegDst,MemtoReg,illegal_op}
  localparam logic [15:0] Idle   = 16'h0800;
  localparam logic [15:0] EnMask = 16'hC059;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst[0]), .Op(op), .Funct(funct),
    .PCWrite(pcw[0]), .Branch(br[0]), .PCSrc(pcsrc[0]), .ALUControl(aluc[0]),
    .ALUSrcB(srcb[0]), .ALUSrcA(srca[0]), .RegWrite(rw[0]), .lorD(lord[0]),
    .MemWrite(mw[0]), .IRWrite(irw[0]), .RegDst(rd[0]), .MemtoReg(m2r[0]),
`ifdef CTRL_PERF_CNT_EN
    .illegal_op(ill[0]), .cycle_cnt(ccnt[0]), .instr_cnt(icnt[0])
`else
    .illegal_op(ill[0])
`endif
  );

  multicycle_ctrl_fsm #(.MEM_RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst[1]), .Op(op), .Funct(funct),
    .PCWrite(pcw[1]), .Branch(br[1]), .PCSrc(pcsrc[1]), .ALUControl(aluc[1]),
    .ALUSrcB(srcb[1]), .ALUSrcA(srca[1]), .RegWrite(rw[1]), .lorD(lord[1]),
    .MemWrite(mw[1]), .IRWrite(irw[1]), .RegDst(rd[1]), .MemtoReg(m2r[1]),
`ifdef CTRL_PERF_CNT_EN
    .illegal_op(ill[1]), .cycle_cnt(ccnt[1]), .instr_cnt(icnt[1])
`else
    .illegal_op(ill[1])
`endif
  );

  assign obs[0] = {pcw[0], br[0], pcsrc[0], aluc[0], srcb[0], srca[0], rw[0], lord[0],
                   mw[0], irw[0], rd[0], m2r[0], ill[0]};
  assign obs[1] = {pcw[1], br[1], pcsrc[1], aluc[1], srcb[1], srca[1], rw[1], lord[1],
                   mw[1], irw[1], rd[1], m2r[1], ill[1]};

  function automatic logic [15:0] mk(input logic p_pcw, input logic p_br, input logic p_pcsrc,
                                     input logic [2:0] p_alu, input logic [1:0] p_srcb,
                                     input logic p_srca, input logic p_rw, input logic p_lord,
                                     input logic p_mw, input logic p_irw, input logic p_rd,
                                     input logic p_m2r, input logic p_ill);
    return {p_pcw, p_br, p_pcsrc, p_alu, p_srcb, p_srca, p_rw, p_lord, p_mw, p_irw, p_rd,
            p_m2r, p_ill};
  endfunction

  // Expected cycle-by-cycle outputs for one whole instruction
  task automatic model(input logic [5:0] m_op, input logic [5:0] m_fn, input int lat);
    logic [2:0] r_alu;
    logic       r_ok;
    exp_q.delete();
    repeat (lat) exp_q.push_back(Idle);
    exp_q.push_back(mk(1, 0, 0, 3'b010, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0));
    if (!(m_op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000})) begin
      exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
    case (m_op)
      6'b100011: begin
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (lat) exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
      end
      6'b101011: begin
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      6'b000100: exp_q.push_back(mk(0, 1, 1, 3'b110, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0));
      6'b001000: begin
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
      end
      default: begin
        r_ok = 1'b1;
        case (m_fn)
          6'b100000: r_alu = 3'b010;
          6'b100010: r_alu = 3'b110;
          6'b100100: r_alu = 3'b000;
          6'b100101: r_alu = 3'b001;
          6'b101010: r_alu = 3'b111;
          default: begin r_alu = 3'b010; r_ok = 1'b0; end
        endcase
        exp_q.push_back(mk(0, 0, 0, r_alu, 2'b00, 1, 0, 0, 0, 0, 0, 0, !r_ok));
        if (r_ok) exp_q.push_back(mk(0, 0, 0, 3'b010, 2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, got, want);
    end
  endtask

  // Run one instruction on instance sel; if abort_at >= 0, drop reset in that cycle
  task automatic run_instr(input int sel, input logic [5:0] i_op, input logic [5:0] i_fn,
                           input string tag, input int abort_at);
    model(i_op, i_fn, (sel == 0) ? 1 : 3);
    op    = i_op;
    funct = i_fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        rst[sel] = 1'b0;
        #1 check({tag, "_rstcyc"}, obs[sel], exp_q[i] & ~EnMask);
        @(negedge clk);
        return;
      end
      #1 check(tag, obs[sel], exp_q[i]);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int sel);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check("reset", obs[sel], Idle);
    end
`ifdef CTRL_PERF_CNT_EN
    vectors++;
    assert (ccnt[sel] === 32'd0 && icnt[sel] === 32'd0) else begin
      miscompares++;
      $error("FAIL perf_reset: observed %0d/%0d expected 0/0", ccnt[sel], icnt[sel]);
    end
`endif
    rst[sel] = 1'b1;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_fn();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    op     = 6'b0;
    funct  = 6'b0;

    // MEM_RD_LAT = 1 instance
    do_reset(0);
    run_instr(0, 6'b000000, 6'b100010, "rtype_sub", -1);
    run_instr(0, 6'b100011, 6'b000000, "lw", -1);
    run_instr(0, 6'b101011, 6'b000000, "sw", -1);
    run_instr(0, 6'b000100, 6'b000000, "beq", -1);
    run_instr(0, 6'b001000, 6'b000000, "addi", -1);
    run_instr(0, 6'b111111, 6'b000000, "illegal_op", -1);
    run_instr(0, 6'b000000, 6'b000111, "illegal_funct", -1);
    run_instr(0, 6'b000000, 6'b101010, "rtype_slt", -1);
    for (int n = 0; n < 40; n++) run_instr(0, rand_op(), rand_fn(), "rand_lat1", -1);

    // Reset dropped in the MEMWR cycle of a store
    run_instr(0, 6'b101011, 6'b000000, "sw_abort", 4);
    #1 check("abort_reset_state", obs[0], Idle);
    rst[0] = 1'b1;
    run_instr(0, 6'b100011, 6'b000000, "lw_after_abort", -1);

    // MEM_RD_LAT = 3 instance
    do_reset(1);
    run_instr(1, 6'b100011, 6'b000000, "lw_lat3", -1);
    run_instr(1, 6'b101011, 6'b000000, "sw_lat3", -1);
    run_instr(1, 6'b000000, 6'b100000, "rtype_add_lat3", -1);
    for (int n = 0; n < 20; n++) run_instr(1, rand_op(), rand_fn(), "rand_lat3", -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
